// File: rtl/conversor_int_flt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : conversor_int_flt_pkg
//  Description : Shared FSM encoding and exponent constants for the
//                integer-to-float converter.
//  Revision    : 1.0 - initial release
// ============================================================================
package conversor_int_flt_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_NORM  = 2'd1;
    localparam logic [1:0] ST_ROUND = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [7:0] BIAS     = 8'd127;
    // Exponent of a value whose leading one sits at bit 31
    localparam logic [7:0] EXP_TOPO = BIAS + 8'd31;

endpackage
`default_nettype wire

// File: rtl/conversor_int_flt_arredondador.sv
`default_nettype none
// ============================================================================
//  Module      : arredondador_rne
//  Description : Round-to-nearest-even of a normalised 32-bit magnitude down
//                to a 23-bit fraction, with exponent carry on overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module arredondador_rne (
    input  logic [31:0] mag,
    input  logic [7:0]  exponent,
    output logic [22:0] fraction,
    output logic [7:0]  exponent_adj
);

    logic        w_lsb;
    logic        w_guard;
    logic        w_sticky;
    logic        w_inc;
    logic [23:0] w_sum;
    // Bit 31 is the implicit leading one and never reaches the fraction
    logic        w_unused_lead;

    assign w_unused_lead = mag[31];
    assign w_lsb         = mag[8];
    assign w_guard       = mag[7];
    assign w_sticky      = |mag[6:0];
    assign w_inc         = w_guard & (w_sticky | w_lsb);
    assign w_sum         = {1'b0, mag[30:8]} + {23'd0, w_inc};

    always_comb begin
        fraction     = w_sum[22:0];
        exponent_adj = exponent;
        if (w_sum[23]) begin
            fraction     = 23'd0;
            exponent_adj = exponent + 8'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/conversor_int_flt.sv
`default_nettype none
// ============================================================================
//  Module      : conversor_int_flt
//  Description : Multi-cycle 32-bit signed/unsigned integer to IEEE-754
//                single-precision converter (shift-normalise, then RNE).
//  Revision    : 1.0 - initial release
// ============================================================================
module conversor_int_flt
    import conversor_int_flt_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic        com_sinal,
    input  logic        start,
    output logic [31:0] s,
    output logic        finish
);

    logic [1:0]  r_state;
    logic [31:0] r_mag;
    logic [7:0]  r_exp;
    logic        r_sign;
    logic [31:0] r_s;
    logic        r_finish;

    logic        w_sign_in;
    logic [31:0] w_mag_in;
    logic [22:0] w_frac;
    logic [7:0]  w_exp_rnd;

    // Negating 0x80000000 wraps to itself, which is the correct magnitude
    assign w_sign_in = com_sinal & a[31];
    assign w_mag_in  = w_sign_in ? (~a + 32'd1) : a;

    arredondador_rne u_rne (
        .mag          (r_mag),
        .exponent     (r_exp),
        .fraction     (w_frac),
        .exponent_adj (w_exp_rnd)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_mag    <= 32'd0;
            r_exp    <= 8'd0;
            r_sign   <= 1'b0;
            r_s      <= 32'd0;
            r_finish <= 1'b0;
        end else begin
            r_finish <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_sign <= w_sign_in;
                        r_mag  <= w_mag_in;
                        r_exp  <= EXP_TOPO;
                        if (w_mag_in == 32'd0) begin
                            r_s     <= 32'd0;
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_NORM;
                        end
                    end
                end
                ST_NORM: begin
                    if (!r_mag[31]) begin
                        r_mag <= {r_mag[30:0], 1'b0};
                        r_exp <= r_exp - 8'd1;
                    end else begin
                        r_state <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    r_s     <= {r_sign, w_exp_rnd, w_frac};
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_finish <= 1'b1;
                    r_state  <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign s      = r_s;
    assign finish = r_finish;

endmodule
`default_nettype wire

// File: tb/tb_conversor_int_flt.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conversor_int_flt
//  Description : Self-checking bench for conversor_int_flt: directed corner
//                cases plus random operands against an arithmetic float model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conversor_int_flt;

    logic        clk;
    logic        reset;
    logic [31:0] a;
    logic        com_sinal;
    logic        start;
    logic [31:0] s;
    logic        finish;

    int tests_run;
    int tests_failed;

    conversor_int_flt dut (
        .clk       (clk),
        .reset     (reset),
        .a         (a),
        .com_sinal (com_sinal),
        .start     (start),
        .s         (s),
        .finish    (finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests_run++;
        assert (obs === exp_v) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Float value and latency derived from the integer's numeric value
    task automatic ref_model(input logic [31:0] av, input logic cs,
                             output logic [31:0] f, output int lat);
        longint mag, q, rem, half;
        int     p, e, sh;
        logic   sg;
        sg  = cs & av[31];
        mag = sg ? (longint'(64'h1_0000_0000) - longint'(av)) : longint'(av);
        if (mag == 0) begin
            f   = 32'd0;
            lat = 1;
            return;
        end
        p = 0;
        for (int i = 0; i < 32; i++)
            if (mag >= (longint'(1) << i)) p = i;
        e = 127 + p;
        if (p <= 23) begin
            q = mag << (23 - p);
        end else begin
            sh   = p - 23;
            q    = mag >> sh;
            rem  = mag - (q << sh);
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
            if (q == (longint'(1) << 24)) begin
                q = q >> 1;
                e = e + 1;
            end
        end
        f   = {sg, e[7:0], q[22:0]};
        lat = (31 - p) + 3;
    endtask

    // Called just after a falling edge with the DUT idle
    task automatic run_conv(input logic [31:0] av, input logic cs,
                            input logic [31:0] exp_s, input int exp_lat, input string tag);
        int lat;
        a         = av;
        com_sinal = cs;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        lat   = 0;
        while (finish !== 1'b1 && lat < 80) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " result"}, s, exp_s);
        @(posedge clk);
        @(negedge clk);
        check({tag, " finish width"}, {31'd0, finish}, 32'd0);
        check({tag, " hold"}, s, exp_s);
    endtask

    initial begin
        logic [31:0] ra, es;
        logic        rc;
        int          el, first_lat, pulses;

        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        a            = 32'd0;
        com_sinal    = 1'b0;
        start        = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset s", s, 32'd0);
        check("reset finish", {31'd0, finish}, 32'd0);
        reset = 1'b0;

        run_conv(32'h0000_0001, 1'b1, 32'h3F80_0000, 34, "s_one");
        run_conv(32'hFFFF_FFFF, 1'b1, 32'hBF80_0000, 34, "s_minus_one");
        run_conv(32'h8000_0000, 1'b1, 32'hCF00_0000, 3,  "s_min");
        run_conv(32'h0000_0000, 1'b0, 32'h0000_0000, 1,  "u_zero");
        run_conv(32'h0000_0000, 1'b1, 32'h0000_0000, 1,  "s_zero");
        run_conv(32'hFFFF_FFFF, 1'b0, 32'h4F80_0000, 3,  "u_max");
        run_conv(32'h0100_0001, 1'b0, 32'h4B80_0000, 10, "u_tie_even");
        run_conv(32'h0100_0003, 1'b0, 32'h4B80_0002, 10, "u_tie_up");
        run_conv(32'h8000_0000, 1'b0, 32'h4F00_0000, 3,  "u_top_bit");

        // Second start while normalising must be dropped
        a         = 32'h0000_0001;
        com_sinal = 1'b1;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start     = 1'b0;
        first_lat = 0;
        pulses    = 0;
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 5) begin
                a     = 32'h00F0_0000;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (finish === 1'b1) begin
                pulses++;
                if (first_lat == 0) first_lat = k;
            end
        end
        check("ignored start latency", first_lat, 34);
        check("ignored start pulses", pulses, 1);
        check("ignored start result", s, 32'h3F80_0000);

        // Reset in the middle of normalisation aborts the conversion
        a         = 32'h0000_0001;
        com_sinal = 1'b1;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("async reset s", s, 32'd0);
        check("async reset finish", {31'd0, finish}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        run_conv(32'h0100_0003, 1'b0, 32'h4B80_0002, 10, "after_reset");
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (finish === 1'b1) pulses++;
        end
        check("no stray finish", pulses, 0);

        for (int i = 0; i < 40; i++) begin
            ra = $urandom >> $urandom_range(0, 31);
            rc = 1'($urandom_range(0, 1));
            if (i % 5 == 0) ra = ~ra;
            ref_model(ra, rc, es, el);
            run_conv(ra, rc, es, el, "random");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/conversor_int_flt.md
CONVERSOR_INT_FLT -- requirements
Module: conversor_int_flt

Interface
REQ-001 The module SHALL have no parameters; width is fixed at 32 bits.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The module SHALL have port a, input, 32 bits: integer operand, sampled only when start is accepted.
REQ-005 The module SHALL have port com_sinal, input, 1 bit: 1 means a is two's-complement signed, 0 means unsigned; sampled with a.
REQ-006 The module SHALL have port start, input, 1 bit: request a conversion; honoured only in IDLE.
REQ-007 The module SHALL have port s, output, 32 bits: IEEE-754 single-precision result, registered.
REQ-008 The module SHALL have port finish, output, 1 bit: registered, high for exactly one cycle when s holds a new result.

Function
REQ-009 The block SHALL be a four-state FSM: IDLE, NORM, ROUND, DONE.
REQ-010 In IDLE with start=1, it SHALL capture sign = com_sinal & a[31] and magnitude = sign ? (~a+1) : a, with exponent register = 158 (127+31).
REQ-011 If the captured magnitude is 0, the FSM SHALL go IDLE->DONE with s=0x00000000 (+0.0).
REQ-012 Otherwise it SHALL go IDLE->NORM.
REQ-013 In NORM, if magnitude[31]=0, the block SHALL shift magnitude left by one bit, decrement the exponent, and stay in NORM.
REQ-014 In NORM, if magnitude[31]=1, the block SHALL go to ROUND; NORM therefore lasts (leading zeros + 1) cycles, between 1 and 32.
REQ-015 In ROUND, the block SHALL apply round-to-nearest-even: lsb=mag[8], guard=mag[7], sticky=OR(mag[6:0]); increment = guard & (sticky | lsb).
REQ-016 In ROUND, fraction SHALL be mag[30:8] + increment; on 23-bit overflow, fraction=0 and exponent+1.
REQ-017 In ROUND, s SHALL be {sign, exponent, fraction}, and the FSM SHALL go to DONE.
REQ-018 In DONE, finish SHALL be 1 for one cycle, then the FSM SHALL go to IDLE; s SHALL hold its value until the next result is written.
REQ-019 Latency SHALL be: finish high (lz+3) cycles after the start-sampling edge for nonzero inputs, and 1 cycle after for zero.
REQ-020 start SHALL be ignored in NORM, ROUND and DONE; no queuing.
REQ-021 Signed input 0x80000000 SHALL yield magnitude 0x80000000 (negation wraps) and the result 0xCF000000.
REQ-022 Results SHALL never be NaN, infinity or subnormal; the largest output exponent is 159 (from 0xFFFFFFFF unsigned).

Reset
REQ-023 While reset=1, the block SHALL immediately force state=IDLE, s=0x00000000, finish=0, and clear the magnitude, exponent and sign registers.
REQ-024 Reset asserted mid-conversion SHALL abort the conversion with no finish pulse; a start in the first cycle after release SHALL be accepted normally.

Structure
REQ-025 A shared package SHALL hold the FSM state encoding, BIAS=127 and EXP_TOPO=158.
REQ-026 Rounding SHALL be one combinational sub-module, arredondador_rne: input mag[31:0] and exponent; output fraction[22:0] and the adjusted exponent.
REQ-027 All other logic SHALL be in conversor_int_flt.

Verification
REQ-028 Signed a=0x00000001, start pulse -> s=0x3F800000, finish exactly 34 cycles after the start edge.
REQ-029 Signed a=0xFFFFFFFF -> s=0xBF800000; signed a=0x80000000 -> s=0xCF000000, finish 3 cycles after the start edge.
REQ-030 a=0x00000000 with com_sinal at either value -> s=0x00000000, finish 1 cycle after the start edge.
REQ-031 Unsigned a=0xFFFFFFFF -> s=0x4F800000 (rounding carries into the exponent); unsigned a=0x01000001 -> 0x4B800000 (tie to even); a=0x01000003 -> 0x4B800002.
REQ-032 Start a conversion, pulse start again during NORM -> second start ignored, single finish; reset asserted during NORM -> s=0, finish=0, state IDLE, no finish pulse afterwards.
